dma_dimn: RTL and testbench

Parametrised N-dimensional DMA address generator, the next generation of the fixed two-dimensional address generator in the CONV read-DMA path. It accepts a descriptor on a start handshake and emits one buffer address per beat on a valid/ready stream, with first/last and per-dimension end flags. New capabilities:
- configurable dimension count and field widths;
- optional circular-buffer wrap against a programmable limit;
- zero-bubble back-to-back descriptors;
- synchronous abort.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_dimn_if.sv | 45 ++++
 rtl/dma_dim_cnt.sv | 68 ++++++
 rtl/dma_dimn.sv | 160 ++++++++++++++++
 tb/tb_dma_dimn.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the N-dimensional DMA address generator.
// Holds the default field widths, the dimension limit, the bit offsets of the
// descriptor fields within the packed local-instruction word, and the
// controller state encoding.
package dma_pkg;

  // Default widths and the largest supported loop nest.
  localparam int unsigned AwDefault = 11;
  localparam int unsigned SwDefault = 4;
  localparam int unsigned NdMax     = 4;

  // Packed local-instruction word layout, sized for the largest nest:
  // {limit, wrap_en, step[NdMax], size[NdMax], base}
  localparam int unsigned DescBaseOfs  = 0;
  localparam int unsigned DescSizeOfs  = DescBaseOfs + AwDefault;
  localparam int unsigned DescStepOfs  = DescSizeOfs + NdMax * SwDefault;
  localparam int unsigned DescWrapOfs  = DescStepOfs + NdMax * SwDefault;
  localparam int unsigned DescLimitOfs = DescWrapOfs + 1;
  localparam int unsigned DescWidth    = DescLimitOfs + AwDefault;

  // Controller states.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

endpackage

// File: rtl/dma_dimn_if.sv
// Descriptor and beat-stream bundle for dma_dimn.
// slave  : generator side (takes descriptors, produces beats).
// master : client side (issues descriptors and abort, accepts beats).
// Signals:
//   start_base/size/step/wrap_en/limit, start_valid, start_ready : descriptor handshake
//   abort                                                        : discard current descriptor
//   s_addr, s_first, s_last, s_dim_last, s_valid, s_ready        : beat stream
//   busy                                                         : descriptor in progress
interface dma_dimn_if
  import dma_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned ND = 3,
  parameter int unsigned SW = SwDefault
) ();

  logic [AW-1:0]    start_base;
  logic [ND*SW-1:0] start_size;
  logic [ND*SW-1:0] start_step;
  logic             start_wrap_en;
  logic [AW-1:0]    start_limit;
  logic             start_valid;
  logic             start_ready;
  logic             abort;
  logic [AW-1:0]    s_addr;
  logic             s_first;
  logic             s_last;
  logic [ND-1:0]    s_dim_last;
  logic             s_valid;
  logic             s_ready;
  logic             busy;

  modport master (
    output start_base, start_size, start_step, start_wrap_en, start_limit, start_valid,
    output abort, s_ready,
    input  start_ready, s_addr, s_first, s_last, s_dim_last, s_valid, busy
  );

  modport slave (
    input  start_base, start_size, start_step, start_wrap_en, start_limit, start_valid,
    input  abort, s_ready,
    output start_ready, s_addr, s_first, s_last, s_dim_last, s_valid, busy
  );

endinterface

// File: rtl/dma_dim_cnt.sv
// One loop dimension of the DMA address generator.
// Holds the iteration counter and the row pointer for its dimension and offers
// the candidate next pointer (ptr + step, optionally wrapped at limit).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   size, step          : this dimension's iteration count minus 1 and increment
//   wrap_en, limit      : circular-buffer wrap control
//   load, base          : descriptor accept; counter to 0, pointer to base
//   adv                 : this dimension advances (counter + 1, pointer <- ptr_in)
//   clr                 : an outer dimension advances (counter to 0, pointer <- ptr_in)
//   ptr_in              : pointer value chosen by the top-level select
//   at_end, at_end_inc  : counter equals size now / after one increment
//   cand                : candidate next pointer
module dma_dim_cnt
  import dma_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned SW = SwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] size,
  input  logic [SW-1:0] step,
  input  logic          wrap_en,
  input  logic [AW-1:0] limit,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          adv,
  input  logic          clr,
  input  logic [AW-1:0] ptr_in,
  output logic          at_end,
  output logic          at_end_inc,
  output logic [AW-1:0] cand
);

  logic [SW-1:0] cnt_q;
  logic [AW-1:0] ptr_q;
  logic [SW-1:0] cnt_inc;
  logic [AW:0]   sum;
  logic          wrap_hit;

  assign cnt_inc    = cnt_q + SW'(1);
  assign at_end     = (cnt_q == size);
  assign at_end_inc = (cnt_inc == size);

  // One extra bit so the wrap compare sees the true sum.
  assign sum      = {1'b0, ptr_q} + {{(AW + 1 - SW){1'b0}}, step};
  assign wrap_hit = wrap_en && (sum >= {1'b0, limit});
  // Low AW bits of (sum - limit) equal sum[AW-1:0] - limit modulo 2^AW.
  assign cand     = wrap_hit ? (sum[AW-1:0] - limit) : sum[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      ptr_q <= base;
    end else if (adv) begin
      cnt_q <= cnt_inc;
      ptr_q <= ptr_in;
    end else if (clr) begin
      cnt_q <= '0;
      ptr_q <= ptr_in;
    end
  end

endmodule

// File: rtl/dma_dimn.sv
// N-dimensional DMA address generator.
// Accepts a descriptor on the start handshake and emits one address per beat,
// dim0 innermost, with first/last and per-dimension end flags. Supports
// circular wrap, zero-bubble back-to-back descriptors and synchronous abort.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : dma_dimn_if slave (descriptor handshake, abort, beat stream, busy)
module dma_dimn
  import dma_pkg::*;
#(
  parameter int unsigned AW = AwDefault,
  parameter int unsigned ND = 3,
  parameter int unsigned SW = SwDefault
) (
  input logic       clk,
  input logic       rst_n,
  dma_dimn_if.slave bus
);

  logic [0:0]       state_q;
  logic [ND*SW-1:0] size_q;
  logic [ND*SW-1:0] step_q;
  logic             wrap_q;
  logic [AW-1:0]    limit_q;
  logic [AW-1:0]    addr_q;
  logic             first_q;
  logic             valid_q;
  logic [ND-1:0]    dim_last_q;
  logic [ND-1:0]    dim_last_d;

  logic [ND-1:0]    at_end;
  logic [ND-1:0]    at_end_inc;
  logic [ND-1:0]    at_end_nxt;
  logic [AW-1:0]    cand [ND];
  logic [ND-1:0]    sel;
  logic [ND-1:0]    lower;
  logic [AW-1:0]    new_ptr;
  logic             found;
  logic             run_and;

  logic             last;
  logic             fire;
  logic             start_ready;
  logic             accept;
  logic             advance;

  assign last        = dim_last_q[ND-1];
  assign fire        = valid_q && bus.s_ready;
  assign start_ready = !bus.abort && ((state_q == StIdle) || (fire && last));
  assign accept      = bus.start_valid && start_ready;
  // accept only happens on a last beat, so it never overlaps an advance.
  assign advance     = fire && !last && !bus.abort;

  // Lowest dimension not yet at its final iteration advances.
  always_comb begin
    sel     = '0;
    new_ptr = '0;
    found   = 1'b0;
    for (int k = 0; k < ND; k++) begin
      if (!found && !at_end[k]) begin
        sel[k]  = 1'b1;
        new_ptr = cand[k];
        found   = 1'b1;
      end
    end
  end

  // Dimensions below the advancing one restart.
  assign lower = sel - ND'(1);

  // End flags for the beat about to be loaded, from its counter values.
  always_comb begin
    at_end_nxt = '0;
    dim_last_d = '0;
    run_and    = 1'b1;
    for (int j = 0; j < ND; j++) begin
      if (accept) begin
        at_end_nxt[j] = (bus.start_size[j*SW +: SW] == '0);
      end else if (sel[j]) begin
        at_end_nxt[j] = at_end_inc[j];
      end else if (lower[j]) begin
        at_end_nxt[j] = (size_q[j*SW +: SW] == '0);
      end else begin
        at_end_nxt[j] = at_end[j];
      end
      run_and       = run_and & at_end_nxt[j];
      dim_last_d[j] = run_and;
    end
  end

  for (genvar k = 0; k < ND; k++) begin : g_dim
    dma_dim_cnt #(
      .AW (AW),
      .SW (SW)
    ) u_dim (
      .clk        (clk),
      .rst_n      (rst_n),
      .size       (size_q[k*SW +: SW]),
      .step       (step_q[k*SW +: SW]),
      .wrap_en    (wrap_q),
      .limit      (limit_q),
      .load       (accept),
      .base       (bus.start_base),
      .adv        (advance && sel[k]),
      .clr        (advance && lower[k]),
      .ptr_in     (new_ptr),
      .at_end     (at_end[k]),
      .at_end_inc (at_end_inc[k]),
      .cand       (cand[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      size_q     <= '0;
      step_q     <= '0;
      wrap_q     <= 1'b0;
      limit_q    <= '0;
      addr_q     <= '0;
      first_q    <= 1'b0;
      valid_q    <= 1'b0;
      dim_last_q <= '0;
    end else if (bus.abort) begin
      state_q    <= StIdle;
      first_q    <= 1'b0;
      valid_q    <= 1'b0;
      dim_last_q <= '0;
    end else if (accept) begin
      state_q    <= StRun;
      size_q     <= bus.start_size;
      step_q     <= bus.start_step;
      wrap_q     <= bus.start_wrap_en;
      limit_q    <= bus.start_limit;
      addr_q     <= bus.start_base;
      first_q    <= 1'b1;
      valid_q    <= 1'b1;
      dim_last_q <= dim_last_d;
    end else if (fire && last) begin
      state_q    <= StIdle;
      first_q    <= 1'b0;
      valid_q    <= 1'b0;
      dim_last_q <= '0;
    end else if (advance) begin
      addr_q     <= new_ptr;
      first_q    <= 1'b0;
      dim_last_q <= dim_last_d;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.s_addr      = addr_q;
  assign bus.s_first     = first_q;
  assign bus.s_last      = last;
  assign bus.s_dim_last  = dim_last_q;
  assign bus.s_valid     = valid_q;
  assign bus.busy        = valid_q;

endmodule

// File: tb/tb_dma_dimn.sv
// Self-checking bench for dma_dimn (AW=11, ND=3, SW=4).
// Table-driven walk of a 3-D descriptor with backpressure, then directed
// sequences for wrap, back-to-back descriptors, abort and mid-run reset.
module tb_dma_dimn;

  localparam int unsigned AW = 11;
  localparam int unsigned ND = 3;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_dimn_if #(.AW(AW), .ND(ND), .SW(SW)) bus ();

  dma_dimn #(
    .AW (AW),
    .ND (ND),
    .SW (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          rdy;
    logic          vld;
    logic [AW-1:0] addr;
    logic          first;
    logic [ND-1:0] dl;
  } vec_t;

  vec_t tbl[10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] base, input logic [ND*SW-1:0] size,
                        input logic [ND*SW-1:0] stp, input logic wrap,
                        input logic [AW-1:0] limit);
    bus.start_base    = base;
    bus.start_size    = size;
    bus.start_step    = stp;
    bus.start_wrap_en = wrap;
    bus.start_limit   = limit;
    bus.start_valid   = 1'b1;
    #1;
    chk($sformatf("start_ready base %0h", base), 32'(bus.start_ready), 32'd1);
    step();
    bus.start_valid = 1'b0;
  endtask

  // Check one presented beat, then let it be accepted (s_ready assumed high).
  task automatic beat(input string tag, input logic [AW-1:0] addr, input logic first,
                      input logic [ND-1:0] dl);
    chk({tag, " valid"}, 32'(bus.s_valid), 32'd1);
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    chk({tag, " addr"}, 32'(bus.s_addr), 32'(addr));
    chk({tag, " first"}, 32'(bus.s_first), 32'(first));
    chk({tag, " dim_last"}, 32'(bus.s_dim_last), 32'(dl));
    chk({tag, " last"}, 32'(bus.s_last), 32'(dl[ND-1]));
    step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(bus.s_valid), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk_idle(tag);
    chk({tag, " addr"}, 32'(bus.s_addr), 32'd0);
    chk({tag, " first"}, 32'(bus.s_first), 32'd0);
    chk({tag, " last"}, 32'(bus.s_last), 32'd0);
    chk({tag, " dim_last"}, 32'(bus.s_dim_last), 32'd0);
  endtask

  initial begin
    // sizes (2,1,0), steps (1,8,0), base 0x010; beat 2 stalled for 3 cycles.
    tbl[0] = '{1'b1, 1'b1, 11'h010, 1'b1, 3'b000};
    tbl[1] = '{1'b0, 1'b1, 11'h011, 1'b0, 3'b000};
    tbl[2] = '{1'b0, 1'b1, 11'h011, 1'b0, 3'b000};
    tbl[3] = '{1'b0, 1'b1, 11'h011, 1'b0, 3'b000};
    tbl[4] = '{1'b1, 1'b1, 11'h011, 1'b0, 3'b000};
    tbl[5] = '{1'b1, 1'b1, 11'h012, 1'b0, 3'b001};
    tbl[6] = '{1'b1, 1'b1, 11'h018, 1'b0, 3'b000};
    tbl[7] = '{1'b1, 1'b1, 11'h019, 1'b0, 3'b000};
    tbl[8] = '{1'b1, 1'b1, 11'h01A, 1'b0, 3'b111};
    tbl[9] = '{1'b1, 1'b0, 11'h000, 1'b0, 3'b000};

    bus.start_base    = '0;
    bus.start_size    = '0;
    bus.start_step    = '0;
    bus.start_wrap_en = 1'b0;
    bus.start_limit   = '0;
    bus.start_valid   = 1'b0;
    bus.abort         = 1'b0;
    bus.s_ready       = 1'b1;

    // Power-on reset.
    rst_n = 1'b0;
    step();
    step();
    chk_reset("por");
    rst_n = 1'b1;
    #1;
    chk("por start_ready", 32'(bus.start_ready), 32'd1);

    // 3-D walk with backpressure.
    launch(11'h010, 12'h012, 12'h081, 1'b0, 11'h000);
    for (int i = 0; i < 10; i++) begin
      bus.s_ready = tbl[i].rdy;
      chk($sformatf("t3d[%0d] valid", i), 32'(bus.s_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("t3d[%0d] addr", i), 32'(bus.s_addr), 32'(tbl[i].addr));
        chk($sformatf("t3d[%0d] first", i), 32'(bus.s_first), 32'(tbl[i].first));
        chk($sformatf("t3d[%0d] dim_last", i), 32'(bus.s_dim_last), 32'(tbl[i].dl));
        chk($sformatf("t3d[%0d] last", i), 32'(bus.s_last), 32'(tbl[i].dl[ND-1]));
      end
      step();
    end
    bus.s_ready = 1'b1;

    // Circular wrap at limit 0x020.
    launch(11'h01E, 12'h003, 12'h001, 1'b1, 11'h020);
    beat("wrap0", 11'h01E, 1'b1, 3'b000);
    beat("wrap1", 11'h01F, 1'b0, 3'b000);
    beat("wrap2", 11'h000, 1'b0, 3'b000);
    beat("wrap3", 11'h001, 1'b0, 3'b111);
    chk_idle("wrap end");

    // Wrap disabled: plain modulo 2^AW.
    launch(11'h7FE, 12'h003, 12'h001, 1'b0, 11'h000);
    beat("mod0", 11'h7FE, 1'b1, 3'b000);
    beat("mod1", 11'h7FF, 1'b0, 3'b000);
    beat("mod2", 11'h000, 1'b0, 3'b000);
    beat("mod3", 11'h001, 1'b0, 3'b111);
    chk_idle("mod end");

    // Back-to-back: second descriptor offered during the first's last beat.
    launch(11'h050, 12'h001, 12'h001, 1'b0, 11'h000);
    beat("b2b_a0", 11'h050, 1'b1, 3'b000);
    bus.start_base  = 11'h100;
    bus.start_size  = 12'h001;
    bus.start_step  = 12'h001;
    bus.start_valid = 1'b1;
    #1;
    chk("b2b last addr", 32'(bus.s_addr), 32'h051);
    chk("b2b last flag", 32'(bus.s_last), 32'd1);
    chk("b2b start_ready", 32'(bus.start_ready), 32'd1);
    step();
    bus.start_valid = 1'b0;
    beat("b2b_b0", 11'h100, 1'b1, 3'b000);
    beat("b2b_b1", 11'h101, 1'b0, 3'b111);
    chk_idle("b2b end");

    // Abort on beat 3 with a competing start.
    launch(11'h200, 12'h004, 12'h002, 1'b0, 11'h000);
    beat("ab0", 11'h200, 1'b1, 3'b000);
    beat("ab1", 11'h202, 1'b0, 3'b000);
    chk("ab2 addr", 32'(bus.s_addr), 32'h204);
    bus.abort       = 1'b1;
    bus.start_base  = 11'h300;
    bus.start_size  = 12'h001;
    bus.start_step  = 12'h003;
    bus.start_valid = 1'b1;
    #1;
    chk("abort start_ready", 32'(bus.start_ready), 32'd0);
    step();
    chk_idle("abort");
    bus.abort = 1'b0;
    #1;
    chk("post-abort start_ready", 32'(bus.start_ready), 32'd1);
    step();
    bus.start_valid = 1'b0;
    beat("fresh0", 11'h300, 1'b1, 3'b000);
    beat("fresh1", 11'h303, 1'b0, 3'b111);
    chk_idle("fresh end");

    // Reset in the middle of a descriptor.
    launch(11'h400, 12'h005, 12'h001, 1'b0, 11'h000);
    beat("rs0", 11'h400, 1'b1, 3'b000);
    beat("rs1", 11'h401, 1'b0, 3'b000);
    rst_n = 1'b0;
    step();
    chk_reset("midrst");
    rst_n = 1'b1;
    #1;
    chk("midrst start_ready", 32'(bus.start_ready), 32'd1);
    // Zero-size inner dimension: dim0 ends on every beat.
    launch(11'h123, 12'h010, 12'h050, 1'b0, 11'h000);
    beat("rr0", 11'h123, 1'b1, 3'b001);
    beat("rr1", 11'h128, 1'b0, 3'b111);
    chk_idle("rr end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
